// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the digital-lock key entry front end:
//   - DIGIT_W      : width of one encoded digit
//   - DIG_*        : digit codes (DIG_NONE = no digit)
//   - entry_state_t: entry FSM states (IDLE / ENTRY)
//   - key_to_digit : one-hot KEY press -> digit code (KEY[3]=1 .. KEY[0]=4)
//   - is_onehot4   : true when exactly one bit of a 4-bit vector is set
// -----------------------------------------------------------------------------
package lock_pkg;

    localparam int DIGIT_W = 3;

    localparam logic [DIGIT_W-1:0] DIG_NONE = 3'd0;
    localparam logic [DIGIT_W-1:0] DIG_1    = 3'd1;
    localparam logic [DIGIT_W-1:0] DIG_2    = 3'd2;
    localparam logic [DIGIT_W-1:0] DIG_3    = 3'd3;
    localparam logic [DIGIT_W-1:0] DIG_4    = 3'd4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } entry_state_t;

    // The buttons are numbered right to left but digits count left to right,
    // so the leftmost button (KEY[3]) is digit 1.
    function automatic logic [DIGIT_W-1:0] key_to_digit(input logic [3:0] key_onehot);
        logic [DIGIT_W-1:0] dig;
        case (key_onehot)
            4'b1000: dig = DIG_1;
            4'b0100: dig = DIG_2;
            4'b0010: dig = DIG_3;
            4'b0001: dig = DIG_4;
            default: dig = DIG_NONE;
        endcase
        return dig;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Two-flop synchroniser followed by a stable-count debouncer for one button.
// The debounced level flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts
// the count.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  synchronous active-high reset (level released, count cleared)
//   raw    in  asynchronous raw button, 1 = pressed
//   level  out debounced button level
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    // Synchronise the raw input and count consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= CNT_ZERO;
            level      <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                stable_cnt <= CNT_ZERO;
            end else if (stable_cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th disagreeing sample.
                level      <= sync_q2;
                stable_cnt <= CNT_ZERO;
            end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/key_entry_encoder.sv
// -----------------------------------------------------------------------------
// key_entry_encoder
// Front end of the digital lock: debounces the four push-buttons, turns each
// clean single-key press into a digit (KEY[3]=1 .. KEY[0]=4) and packs
// CODE_LEN digits into one entry code, first digit in the MSBs.
//
// Optional feature (compile-time macro ENTRY_TIMEOUT_EN): when defined, a
// partial entry idle for TIMEOUT_CYCLES is discarded and entry_timeout pulses.
// When undefined, entry_timeout stays 0 and partial entries persist.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   KEY[3:0]       in   raw buttons, 1 = pressed, asynchronous
//   clear          in   abandon the current entry (wins over a press)
//   digit[2:0]     out  last accepted digit (1..4), 0 = none
//   digit_valid    out  one-cycle pulse per accepted digit
//   key_error      out  one-cycle pulse per rejected press
//   entry_count    out  digits accepted in the current entry
//   code           out  packed entry code, 3*CODE_LEN bits
//   code_valid     out  one-cycle pulse when an entry completes
//   entry_timeout  out  one-cycle pulse when a partial entry times out
// -----------------------------------------------------------------------------
module key_entry_encoder
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CODE_LEN        = 4,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    KEY,
    input  logic                          clear,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          digit_valid,
    output logic                          key_error,
    output logic [3:0]                    entry_count,
    output logic [DIGIT_W*CODE_LEN-1:0]   code,
    output logic                          code_valid,
    output logic                          entry_timeout
);

    localparam int               CODE_W    = DIGIT_W * CODE_LEN;
    localparam logic [3:0]       LAST_IDX  = 4'(CODE_LEN - 1);

    logic [3:0]          key_level;
    logic [3:0]          level_d;
    logic [3:0]          rise_s;
    logic [3:0]          press_r;
    logic [3:0]          held_r;
    logic                accept_s;
    logic                reject_s;
    logic                last_digit_s;
    logic                timeout_hit_s;
    logic [DIGIT_W-1:0]  press_digit_s;
    logic [CODE_W-1:0]   shift_base_s;
    logic [CODE_W-1:0]   code_shift_s;
    entry_state_t        state_r;

    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (KEY[gi]),
            .level (key_level[gi])
        );
    end

    assign rise_s = key_level & ~level_d;

    // Register press events together with the keys that were already held, so
    // the accept decision sees a consistent snapshot of one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_d <= 4'd0;
            press_r <= 4'd0;
            held_r  <= 4'd0;
        end else begin
            level_d <= key_level;
            press_r <= rise_s;
            held_r  <= key_level & ~rise_s;
        end
    end

    // Accept decision, digit encoding and next packed code.
    always_comb begin
        accept_s      = is_onehot4(press_r) && (held_r == 4'd0);
        reject_s      = (press_r != 4'd0) && !accept_s;
        press_digit_s = key_to_digit(press_r);
        if (state_r == IDLE) begin
            shift_base_s = {CODE_W{1'b0}};
        end else begin
            shift_base_s = code;
        end
        code_shift_s = (shift_base_s << DIGIT_W) | CODE_W'(press_digit_s);
        // entry_count is 0 in IDLE, so this also covers CODE_LEN == 1.
        last_digit_s = (entry_count == LAST_IDX);
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] idle_cnt_r;

    assign timeout_hit_s = (state_r == ENTRY) && (idle_cnt_r == TO_LAST);

    // Idle counter: runs only while a partial entry is open.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_r <= {TO_W{1'b0}};
        end else if (clear || accept_s || timeout_hit_s || (state_r != ENTRY)) begin
            idle_cnt_r <= {TO_W{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_ONE;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Entry FSM and registered outputs; priority is clear > press > timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            digit         <= DIG_NONE;
            digit_valid   <= 1'b0;
            key_error     <= 1'b0;
            entry_count   <= 4'd0;
            code          <= {CODE_W{1'b0}};
            code_valid    <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            digit_valid   <= 1'b0;
            code_valid    <= 1'b0;
            entry_timeout <= 1'b0;
            key_error     <= reject_s;
            if (clear) begin
                state_r     <= IDLE;
                digit       <= DIG_NONE;
                entry_count <= 4'd0;
                code        <= {CODE_W{1'b0}};
            end else if (accept_s) begin
                digit       <= press_digit_s;
                digit_valid <= 1'b1;
                code        <= code_shift_s;
                if (last_digit_s) begin
                    code_valid  <= 1'b1;
                    entry_count <= 4'd0;
                    state_r     <= IDLE;
                end else begin
                    entry_count <= entry_count + 4'd1;
                    state_r     <= ENTRY;
                end
            end else if (timeout_hit_s) begin
                entry_timeout <= 1'b1;
                state_r       <= IDLE;
                digit         <= DIG_NONE;
                entry_count   <= 4'd0;
                code          <= {CODE_W{1'b0}};
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_key_entry_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_entry_encoder
// Self-checking bench for key_entry_encoder with DEBOUNCE_CYCLES=4, CODE_LEN=4,
// TIMEOUT_CYCLES=20. Expected pulses are queued when a press is driven and
// compared by a monitor whenever the DUT emits digit_valid, key_error,
// code_valid or entry_timeout.
// -----------------------------------------------------------------------------
module tb_key_entry_encoder;

    localparam int DEB  = 4;
    localparam int CLEN = 4;
    localparam int TO   = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic        clear;
    logic [2:0]  digit;
    logic        digit_valid;
    logic        key_error;
    logic [3:0]  entry_count;
    logic [11:0] code;
    logic        code_valid;
    logic        entry_timeout;

    typedef struct {
        logic        dv;
        logic        err;
        logic        cv;
        logic        to;
        logic [2:0]  dig;
        logic [11:0] code;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct {
        logic [3:0]  key;
        logic        dv;
        logic        err;
        logic        cv;
        logic [2:0]  dig;
        logic [11:0] code;
        logic [3:0]  cnt;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   checks = 0;
    int   fails  = 0;

    always #5 clock = ~clock;

    key_entry_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .CODE_LEN        (CLEN),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .KEY           (KEY),
        .clear         (clear),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .key_error     (key_error),
        .entry_count   (entry_count),
        .code          (code),
        .code_valid    (code_valid),
        .entry_timeout (entry_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic dv, input logic err, input logic cv, input logic to,
                        input logic [2:0] dig, input logic [11:0] c, input logic [3:0] n);
        exp_t e;
        e.dv = dv; e.err = err; e.cv = cv; e.to = to;
        e.dig = dig; e.code = c; e.cnt = n;
        sb_q.push_back(e);
    endtask

    // Called at a negedge right after driving inputs; lat = edges after edge 0.
    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (digit_valid === 1'b1 || key_error === 1'b1) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic press_hold(input logic [3:0] k);
        @(negedge clock);
        KEY = k;
        repeat (10) @(negedge clock);
        KEY = 4'd0;
        repeat (12) @(negedge clock);
    endtask

    // Scoreboard monitor: every output pulse must match the next queued entry.
    always @(negedge clock) begin
        if (digit_valid === 1'b1 || key_error === 1'b1 ||
            code_valid === 1'b1 || entry_timeout === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse",
                      32'({digit_valid, key_error, code_valid, entry_timeout}), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_flags",
                      32'({digit_valid, key_error, code_valid, entry_timeout}),
                      32'({mon_e.dv, mon_e.err, mon_e.cv, mon_e.to}));
                check("digit", 32'(digit), 32'(mon_e.dig));
                check("code", 32'(code), 32'(mon_e.code));
                check("entry_count", 32'(entry_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        int lat;
        int to_lat;

        vecs[0] = '{4'b1000, 1'b1, 1'b0, 1'b0, 3'd1, 12'h001, 4'd1};
        vecs[1] = '{4'b0100, 1'b1, 1'b0, 1'b0, 3'd2, 12'h00A, 4'd2};
        vecs[2] = '{4'b0010, 1'b1, 1'b0, 1'b0, 3'd3, 12'h053, 4'd3};
        vecs[3] = '{4'b0001, 1'b1, 1'b0, 1'b1, 3'd4, 12'h29C, 4'd0};
        vecs[4] = '{4'b0011, 1'b0, 1'b1, 1'b0, 3'd4, 12'h29C, 4'd0};
        vecs[5] = '{4'b0001, 1'b1, 1'b0, 1'b0, 3'd4, 12'h004, 4'd1};
        vecs[6] = '{4'b0010, 1'b1, 1'b0, 1'b0, 3'd3, 12'h023, 4'd2};
        vecs[7] = '{4'b0100, 1'b1, 1'b0, 1'b0, 3'd2, 12'h11A, 4'd3};
        vecs[8] = '{4'b1000, 1'b1, 1'b0, 1'b1, 3'd1, 12'h8D1, 4'd0};

        reset = 1'b1;
        KEY   = 4'd0;
        clear = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              32'({digit, digit_valid, key_error, entry_count, code, code_valid, entry_timeout}),
              32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single presses, a full entry, a two-key error and a second entry.
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].dv, vecs[i].err, vecs[i].cv, 1'b0,
                 vecs[i].dig, vecs[i].code, vecs[i].cnt);
            KEY = vecs[i].key;
            wait_pulse(lat);
            check("press_latency", 32'(lat), 32'd7);
            KEY = 4'd0;
            repeat (12) @(negedge clock);
        end

        // Short glitch on KEY[2] must be filtered, the long hold accepted once.
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 12'h002, 4'd1);
        KEY = 4'b0100;
        repeat (2) @(negedge clock);
        KEY = 4'd0;
        repeat (2) @(negedge clock);
        KEY = 4'b0100;
        repeat (10) @(negedge clock);
        KEY = 4'd0;
        repeat (12) @(negedge clock);
        check("glitch_sb_drained", 32'(sb_q.size()), 32'd0);

        // Plain clear.
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_outputs", 32'({digit, entry_count, code}), 32'd0);

        // KEY[3] held, then KEY[0] pressed: digit 1 accepted, KEY[0] rejected.
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h001, 4'd1);
        KEY = 4'b1000;
        repeat (12) @(negedge clock);
        push(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 12'h001, 4'd1);
        KEY = 4'b1001;
        wait_pulse(lat);
        check("held_error_latency", 32'(lat), 32'd7);
        repeat (3) @(negedge clock);
        KEY = 4'd0;
        repeat (12) @(negedge clock);
        check("held_error_count", 32'(entry_count), 32'd1);

        // Two digits, then clear coincides with a third accepted press.
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 12'h002, 4'd1);
        press_hold(4'b0100);
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 12'h013, 4'd2);
        press_hold(4'b0010);
        KEY = 4'b0001;
        repeat (7) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_wins_outputs",
              32'({digit, digit_valid, key_error, entry_count, code}), 32'd0);
        repeat (5) @(negedge clock);
        KEY = 4'd0;
        repeat (12) @(negedge clock);
        check("clear_wins_no_retrigger", 32'(entry_count), 32'd0);

        // Reset mid-entry with KEY[1] held: the held key re-registers afterwards.
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 12'h001, 4'd1);
        press_hold(4'b1000);
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 12'h00B, 4'd2);
        KEY = 4'b0010;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_mid_entry_outputs",
              32'({digit, digit_valid, key_error, entry_count, code, code_valid, entry_timeout}),
              32'd0);
        check("reset_sb_drained", 32'(sb_q.size()), 32'd0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 12'h003, 4'd1);
        reset = 1'b0;
        wait_pulse(lat);
        check("post_reset_latency", 32'(lat), 32'd7);
        check("post_reset_digit", 32'({digit, entry_count}), 32'({3'd3, 4'd1}));
        KEY = 4'd0;

`ifdef ENTRY_TIMEOUT_EN
        // Partial entry left idle must time out TIMEOUT_CYCLES after the digit.
        push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 12'h000, 4'd0);
        to_lat = -1;
        for (int n = 1; n < 60; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (entry_timeout === 1'b1) begin
                to_lat = n;
                break;
            end
        end
        check("timeout_latency", 32'(to_lat), 32'd20);
        check("timeout_outputs", 32'({digit, entry_count, code}), 32'd0);
`else
        // Without the timeout feature a partial entry persists.
        to_lat = 0;
        repeat (40) @(negedge clock);
        check("no_timeout_persist", 32'({entry_count, code, entry_timeout}),
              32'({4'd1, 12'h003, 1'b0}));
        check("no_timeout_pulse", 32'(to_lat), 32'd0);
`endif

        repeat (12) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
